arb_fifo_queue: RTL and testbench
=================================

Name: arb_fifo_queue

Overview:
Parametrised first-come-first-served request queue for the PCI arbiter's FIFO mode. It watches all REQ# lines directly and enqueues each newly requesting device ID once, in arrival order. It presents the head ID as the grant candidate to the GNT# decoder and pops the entry when the granted master starts its transaction (FRAME# falling). It replaces the fixed 3-bit / 8-entry queue and adds same-cycle tie-breaking, duplicate suppression, withdrawal handling and flush on mode change.

Parameters:
N_DEV, 8, number of bus masters (REQ#/GNT# pairs), 2..32
ID_W, 3, device ID width, must satisfy 2**ID_W >= N_DEV
DEPTH, 8, queue entries, power of two, >= 2; DEPTH < N_DEV is legal
CNT_W, 4, occupancy counter width, must satisfy 2**CNT_W > DEPTH

Ports:
clk  input  1  bus clock; all state changes on posedge
reset  input  1  asynchronous, active-low; clears all state immediately
priority_enable  input  1  1 = arbiter in priority mode: block idle and flushed; 0 = FIFO mode active
req_n  input  N_DEV  active-low REQ# per device, bit i = device i
frame_n  input  1  active-low PCI FRAME#
gnt_id  output  ID_W  device ID at queue head
gnt_valid  output  1  gnt_id is a valid grant candidate
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (reset=0, async): rd_ptr=0, wr_ptr=0, count=0, queued mask=0, frame_q=1. Outputs gnt_valid=0, gnt_id=0, count=0, full=0, empty=1. Effective mid-transaction with no clock required.
- queued[i]=1 while device i's ID is in the queue. This guarantees at most one entry per device.
- eligible[i] = (req_n[i]==0) && !queued[i].
- Push: each posedge with priority_enable=0 and no eligible-blocking full condition, write the lowest-index eligible ID at wr_ptr, set its queued bit, advance wr_ptr. Only one push per cycle. Remaining eligible devices push on subsequent cycles in ascending index order.
- Full blocks the push unless a pop occurs in the same cycle. A full queue with a same-cycle pop accepts the push.
- frame_fall = (frame_q==1 && frame_n==0); frame_q <= frame_n every posedge.
- Grant pop: frame_fall && gnt_valid. Pop the head, clear queued[head], advance rd_ptr.
- Withdrawal drop: if !empty and req_n[head]==1 and !frame_fall, pop the head without grant in that cycle. At most one pop per cycle.
- Re-request: a device still holding REQ# after its pop becomes eligible the next cycle. It re-enqueues behind current entries (round fairness).
- Push and pop in the same cycle: count unchanged, both pointers advance. A device popped this cycle cannot be pushed in the same cycle, because queued is cleared at the clock edge.
- Pointers are ID-indexed mod DEPTH and wrap naturally. count is never decremented below 0 or incremented above DEPTH.
- Outputs: gnt_id = mem[rd_ptr] (combinational from registers); gnt_valid = !empty && priority_enable==0. When empty, gnt_id=0.
- Latency: REQ# asserted before edge k with the queue empty gives gnt_valid=1 after edge k (1 cycle).
- priority_enable=1: synchronous flush on each posedge (pointers, count, queued cleared), no push/pop, gnt_valid=0. frame_q still tracks frame_n.
- FRAME# falling while empty, or while disabled: ignored.

Test Plan:
1. Reset mid-operation: queue holding IDs 2,5; pulse reset low between clock edges -> count=0, empty=1, gnt_valid=0 immediately; no entries reappear after reset release.
2. Ordering: req_n[3] low at cycle 1, req_n[1] low at cycle 3 -> queue 3,1; gnt_id=3; FRAME# falls -> gnt_id=1 next cycle, count=1.
3. Tie-break and duplicates: req_n=8'b1010_0101 in one cycle (devices 1,3,4,6 active), held low -> pushes 1,3,4,6 over 4 cycles; count=4, never >4 while REQ# held.
4. Withdrawal and re-request: head=2 deasserts REQ# -> dropped in 1 cycle, gnt_id moves to next entry with no FRAME#. Device 0 holds REQ# through its FRAME# fall -> re-enqueued at tail the next cycle.
5. Full/wrap with DEPTH=4, N_DEV=8: all REQ# low -> count saturates at 4 with full=1 and pending IDs held. Pop plus push in the same cycle keeps count=4. After 10 grants the order is 0,1,2,3,4,5,6,7,0,1 across the pointer wrap.
6. Mode switch: queue holds 3 entries, then priority_enable=1 -> next posedge count=0, gnt_valid=0, and FRAME# is ignored. Return to 0 with REQ# held -> re-enqueue from ascending index.

Source files
------------

// File: rtl/arb_fifo_queue.sv
// rtl/arb_fifo_queue.sv - FCFS REQ# queue for the PCI arbiter FIFO mode
// Enqueues each new requester once, presents the head as grant candidate, pops on FRAME# fall or withdrawal.
module arb_fifo_queue #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             priority_enable,
  input  logic [N_DEV-1:0] req_n,
  input  logic             frame_n,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [N_DEV-1:0] queued;
  logic [N_DEV-1:0] queued_nxt;
  logic [N_DEV-1:0] eligible;
  logic             frame_q;
  logic             frame_fall;
  logic [ID_W-1:0]  head_id;
  logic [ID_W-1:0]  push_id;
  logic             push_found;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign head_id    = mem[rd_ptr];
  assign gnt_valid  = !empty && !priority_enable;
  assign gnt_id     = empty ? '0 : head_id;
  assign frame_fall = frame_q && !frame_n;
  assign eligible   = ~req_n & ~queued;

  // Descending scan so the lowest-index eligible device is the one left standing.
  always_comb begin
    push_found = 1'b0;
    push_id    = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        push_found = 1'b1;
        push_id    = ID_W'(i);
      end
    end
  end

  // A head whose REQ# is gone is dropped unless it is being granted this very edge.
  assign do_pop  = gnt_valid && (frame_fall || req_n[head_id]);
  assign do_push = !priority_enable && push_found && (!full || do_pop);

  always_comb begin
    queued_nxt = queued;
    if (do_pop) queued_nxt[head_id] = 1'b0;
    if (do_push) queued_nxt[push_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      queued  <= '0;
      frame_q <= 1'b1;
    end else begin
      frame_q <= frame_n;
      if (priority_enable) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        queued <= '0;
      end else begin
        queued <= queued_nxt;
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage needs no reset: it is only visible through gnt_id while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: tb/tb_arb_fifo_queue.sv
// tb/tb_arb_fifo_queue.sv - randomized and directed bench for arb_fifo_queue
// Reference model keeps the queue as a list of device IDs and applies the arrival/grant/drop rules directly.
module tb_arb_fifo_queue;
  localparam int N_DEV = 8;
  localparam int ID_W  = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             priority_enable = 1'b0;
  logic [N_DEV-1:0] req_n = '1;
  logic             frame_n = 1'b1;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [9:0]       dut_vec;

  int n_cmp = 0;
  int n_err = 0;
  int q[$];
  logic m_fq = 1'b1;

  arb_fifo_queue #(.N_DEV(N_DEV), .ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .priority_enable(priority_enable), .req_n(req_n),
    .frame_n(frame_n), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  assign dut_vec = {gnt_valid, gnt_id, count, full, empty};

  function automatic bit in_q(int id);
    foreach (q[k]) if (q[k] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] model_vec();
    logic v;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] c;
    v  = (q.size() > 0) && !priority_enable;
    id = (q.size() > 0) ? ID_W'(q[0]) : '0;
    c  = CNT_W'(q.size());
    return {v, id, c, q.size() == DEPTH, q.size() == 0};
  endfunction

  // Advance the model with the inputs now applied, then clock the DUT once.
  task automatic step();
    bit pop;
    int pid;
    if (priority_enable) begin
      q.delete();
    end else begin
      pop = (q.size() > 0) && ((m_fq && !frame_n) || req_n[q[0]]);
      pid = -1;
      for (int i = 0; i < N_DEV && pid < 0; i++)
        if (!req_n[i] && !in_q(i)) pid = i;
      if (pop) void'(q.pop_front());
      if (pid >= 0 && q.size() < DEPTH) q.push_back(pid);
    end
    m_fq = frame_n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({gnt_valid, count, full, empty} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state got=%b want=%b", {gnt_valid, count, full, empty}, 7'b0000001);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    req_n[2] = 1'b0;
    req_n[5] = 1'b0;
    step();
    step();
    n_cmp++;
    if (dut_vec !== model_vec() || gnt_id !== 3'd2) begin
      n_err++;
      $display("FAIL reset_fill got=%h want=%h", dut_vec, model_vec());
    end
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({gnt_valid, count, empty} !== {1'b0, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_async got=%b want=%b", {gnt_valid, count, empty}, 6'b000001);
    end
    q.delete();
    m_fq = 1'b1;
    req_n = '1;
    #2;
    reset = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== model_vec() || count !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release got=%h want=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_ordering();
    req_n[3] = 1'b0;
    step();
    step();
    req_n[1] = 1'b0;
    step();
    n_cmp++;
    if (gnt_id !== 3'd3 || count !== 4'd2 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL order_head got=%h want=%h", dut_vec, model_vec());
    end
    req_n[3] = 1'b1;
    frame_n = 1'b0;
    step();
    n_cmp++;
    if (gnt_id !== 3'd1 || count !== 4'd1 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL order_grant got=%h want=%h", dut_vec, model_vec());
    end
    frame_n = 1'b1;
    req_n[1] = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== model_vec() || empty !== 1'b1) begin
      n_err++;
      $display("FAIL order_drain got=%h want=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_tie_break();
    req_n = 8'b1010_0101;
    for (int c = 0; c < 6; c++) begin
      step();
      n_cmp++;
      if (dut_vec !== model_vec() || count > 4'd4) begin
        n_err++;
        $display("FAIL tie_cycle%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (gnt_id !== 3'd1 || count !== 4'd4 || full !== 1'b1) begin
      n_err++;
      $display("FAIL tie_final got id=%0d cnt=%0d full=%b want id=1 cnt=4 full=1", gnt_id, count, full);
    end
    req_n = '1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL tie_drop%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_withdrawal();
    req_n[2] = 1'b0;
    step();
    req_n[0] = 1'b0;
    step();
    req_n[2] = 1'b1;
    step();
    n_cmp++;
    if (gnt_id !== 3'd0 || count !== 4'd1 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL withdraw_drop got=%h want=%h", dut_vec, model_vec());
    end
    frame_n = 1'b0;
    step();
    n_cmp++;
    if (count !== 4'd0 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL withdraw_grant got=%h want=%h", dut_vec, model_vec());
    end
    frame_n = 1'b1;
    step();
    n_cmp++;
    if (count !== 4'd1 || gnt_id !== 3'd0 || gnt_valid !== 1'b1 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL withdraw_requeue got=%h want=%h", dut_vec, model_vec());
    end
    req_n = '1;
    step();
  endtask

  task automatic test_full_wrap();
    int waited;
    req_n = '0;
    for (int c = 0; c < 5; c++) step();
    n_cmp++;
    if (count !== 4'd4 || full !== 1'b1 || gnt_id !== 3'd0 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL full_sat got=%h want=%h", dut_vec, model_vec());
    end
    for (int g = 0; g < 10; g++) begin
      if (g == 8) req_n = '0;
      waited = 0;
      while (!gnt_valid && waited < 20) begin
        step();
        waited++;
      end
      n_cmp++;
      if (!gnt_valid || gnt_id !== ID_W'(g % 8)) begin
        n_err++;
        $display("FAIL wrap_order%0d got valid=%b id=%0d want valid=1 id=%0d", g, gnt_valid, gnt_id, g % 8);
      end
      req_n[gnt_id] = 1'b1;
      frame_n = 1'b0;
      step();
      n_cmp++;
      if (dut_vec !== model_vec() || (g < 4 && count !== 4'd4)) begin
        n_err++;
        $display("FAIL wrap_pop%0d got=%h want=%h", g, dut_vec, model_vec());
      end
      frame_n = 1'b1;
      step();
    end
    req_n = '1;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_mode_switch();
    req_n = 8'b1111_0001;
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (count !== 4'd3 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL mode_fill got=%h want=%h", dut_vec, model_vec());
    end
    priority_enable = 1'b1;
    step();
    frame_n = 1'b0;
    step();
    n_cmp++;
    if (count !== 4'd0 || gnt_valid !== 1'b0 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL mode_flush got=%h want=%h", dut_vec, model_vec());
    end
    frame_n = 1'b1;
    priority_enable = 1'b0;
    step();
    n_cmp++;
    if (gnt_id !== 3'd1 || count !== 4'd1 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL mode_resume got=%h want=%h", dut_vec, model_vec());
    end
    step();
    step();
    n_cmp++;
    if (count !== 4'd3 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL mode_refill got=%h want=%h", dut_vec, model_vec());
    end
    req_n = '1;
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0) req_n = N_DEV'($urandom | $urandom);
      frame_n = ($urandom_range(2) != 0);
      priority_enable = ($urandom_range(24) == 0);
      step();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL random_cycle%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_tie_break();
    test_withdrawal();
    test_full_wrap();
    test_mode_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
